// File: rtl/matmul_bram_arb_if.sv
// Requester and BRAM-side signals of one operand-memory arbiter.
// slave: the arbiter; master: the host/engine requesters together with the BRAM.
interface matmul_bram_arb_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  req0, req1;
  logic                  we0, we1;
  logic                  lock0, lock1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  gnt0, gnt1;
  logic                  rvalid0, rvalid1;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  bram_en;
  logic                  bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_din;
  logic [DATA_WIDTH-1:0] bram_dout;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, bram_dout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, bram_en, bram_we, bram_addr, bram_din
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, bram_dout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, bram_en, bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/matmul_bram_arb.sv
// Round-robin arbiter sharing one single-port BRAM between host (0) and engine (1),
// with bounded ownership lock, registered BRAM port and tagged read-return pipeline.
module matmul_bram_arb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned MAX_LOCK   = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  matmul_bram_arb_if.slave    bus
);

  localparam int unsigned CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  lock_q, lock_d;
  logic [CW-1:0]         lock_cnt_q, lock_cnt_d;

  logic                  bram_en_q, bram_en_d;
  logic                  bram_we_q, bram_we_d;
  logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_WIDTH-1:0] bram_din_q, bram_din_d;

  logic                  rd_v1_q, rd_v1_d, rd_id1_q, rd_id1_d;
  logic                  rd_v2_q, rd_v2_d, rd_id2_q, rd_id2_d;

  logic                  grant_any;
  logic                  grant_id;
  logic                  sel_we;
  logic                  sel_lock;
  logic                  same_owner;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      lock_q      <= 1'b0;
      lock_cnt_q  <= '0;
      bram_en_q   <= 1'b0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      rd_v1_q     <= 1'b0;
      rd_id1_q    <= 1'b0;
      rd_v2_q     <= 1'b0;
      rd_id2_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      lock_cnt_q  <= lock_cnt_d;
      bram_en_q   <= bram_en_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      rd_v1_q     <= rd_v1_d;
      rd_id1_q    <= rd_id1_d;
      rd_v2_q     <= rd_v2_d;
      rd_id2_q    <= rd_id2_d;
    end
  end

  // Next-state: grant decision, ownership, pointer, lock counter, BRAM access
  always_comb begin
    grant_any   = 1'b0;
    grant_id    = 1'b0;
    if (state_q == OWN0 && lock_q && bus.req0 && lock_cnt_q < LOCK_MAX) begin
      grant_any = 1'b1;
      grant_id  = 1'b0;
    end else if (state_q == OWN1 && lock_q && bus.req1 && lock_cnt_q < LOCK_MAX) begin
      grant_any = 1'b1;
      grant_id  = 1'b1;
    end else if (bus.req0 && bus.req1) begin
      grant_any = 1'b1;
      grant_id  = ptr_q;
    end else if (bus.req0 || bus.req1) begin
      grant_any = 1'b1;
      grant_id  = bus.req1;
    end

    sel_we     = grant_id ? bus.we1   : bus.we0;
    sel_lock   = grant_id ? bus.lock1 : bus.lock0;
    same_owner = grant_id ? (state_q == OWN1) : (state_q == OWN0);

    state_d     = IDLE;
    ptr_d       = ptr_q;
    lock_d      = 1'b0;
    lock_cnt_d  = '0;
    bram_en_d   = 1'b0;
    bram_we_d   = 1'b0;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;

    if (grant_any) begin
      state_d     = grant_id ? OWN1 : OWN0;
      ptr_d       = ~grant_id;
      lock_d      = sel_lock;
      bram_en_d   = 1'b1;
      bram_we_d   = sel_we;
      bram_addr_d = grant_id ? bus.addr1  : bus.addr0;
      bram_din_d  = grant_id ? bus.wdata1 : bus.wdata0;
      // lock_cnt counts the current run of locked grants, including the first one
      if (sel_lock) begin
        if (same_owner && lock_q)
          lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + CW'(1);
        else
          lock_cnt_d = CW'(1);
      end
    end

    rd_v1_d  = grant_any & ~sel_we;
    rd_id1_d = grant_id;
    rd_v2_d  = rd_v1_q;
    rd_id2_d = rd_id1_q;
  end

  // Outputs
  always_comb begin
    bus.gnt0      = rst_n & grant_any & ~grant_id;
    bus.gnt1      = rst_n & grant_any &  grant_id;
    bus.rvalid0   = rd_v2_q & ~rd_id2_q;
    bus.rvalid1   = rd_v2_q &  rd_id2_q;
    bus.rdata     = rd_v2_q ? bus.bram_dout : '0;
    bus.bram_en   = bram_en_q;
    bus.bram_we   = bram_we_q;
    bus.bram_addr = bram_addr_q;
    bus.bram_din  = bram_din_q;
  end

endmodule
